// File: rtl/mul8_share_arb.sv
// ---------------------------------------------------------------------------
// mul8_share_arb
//   Shares one external sequential 8x8 shift-add multiplier among N
//   requesters. An idle arbiter picks one requester, latches its operands,
//   pulses the core's start, waits out the core's busy window and returns
//   the 8-bit product together with the requester index.
//
//   Optional build macro: MUL8_SHARE_ARB_FIXED_PRIO_EN
//     defined   : fixed priority, lowest requester index wins (no pointer)
//     undefined : round-robin starting from the slot after the last winner
//
// Parameters
//   N     number of requesters (2..8)
//   ID_W  width of the requester index, 2**ID_W >= N
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester level request
//   a_bus      operand A, requester k on [8k+7:8k]
//   b_bus      operand B, same packing
//   ack        one-cycle completion pulse to the served requester
//   res_valid  one-cycle pulse, result fields valid
//   res_id     index of the served requester
//   res_p      product (a*b) mod 256
//   arb_busy   high whenever the FSM is not idle
//   mul_start  start pulse to the multiplier core
//   mul_a      latched operand A to the core
//   mul_b      latched operand B to the core
//   mul_busy   core busy, high 8 cycles starting the cycle after start
//   mul_p      core product, stable while mul_busy is low
// ---------------------------------------------------------------------------
module mul8_share_arb #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req,
   input  logic [8*N-1:0]    a_bus,
   input  logic [8*N-1:0]    b_bus,
   output logic [N-1:0]      ack,
   output logic              res_valid,
   output logic [ID_W-1:0]   res_id,
   output logic [7:0]        res_p,
   output logic              arb_busy,
   output logic              mul_start,
   output logic [7:0]        mul_a,
   output logic [7:0]        mul_b,
   input  logic              mul_busy,
   input  logic [7:0]        mul_p
);

   localparam int CW = ID_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic                r_run_first;
   logic [ID_W-1:0]     r_id;
   logic [N-1:0]        r_ack;
   logic                r_res_valid;
   logic [ID_W-1:0]     r_res_id;
   logic [7:0]          r_res_p;
   logic                r_arb_busy;
   logic                r_mul_start;
   logic [7:0]          r_mul_a;
   logic [7:0]          r_mul_b;

`ifndef MUL8_SHARE_ARB_FIXED_PRIO_EN
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);
   logic [ID_W-1:0]     r_ptr;
`endif

   logic [CW-1:0]       w_cand;
   logic                w_found;
   logic [ID_W-1:0]     w_win;
   logic [7:0]          w_a;
   logic [7:0]          w_b;

   // Winner search: candidates are visited in priority order; the first
   // asserted request wins. The one-bit-wider candidate lets the round-robin
   // sum ptr+i wrap for N that is not a power of two.
   always_comb begin
      w_cand  = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned i = 0; i < N; i++) begin
`ifdef MUL8_SHARE_ARB_FIXED_PRIO_EN
         w_cand = CW'(i);
`else
         w_cand = {1'b0, r_ptr} + CW'(i);
         if (w_cand >= CW'(N)) begin
            w_cand = w_cand - CW'(N);
         end
`endif
         if (!w_found && req[w_cand[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (w_win == ID_W'(k)) begin
            w_a = a_bus[8*k +: 8];
            w_b = b_bus[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_run_first <= 1'b0;
         r_id        <= '0;
         r_ack       <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_p     <= '0;
         r_arb_busy  <= 1'b0;
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
`ifndef MUL8_SHARE_ARB_FIXED_PRIO_EN
         r_ptr       <= '0;
`endif
      end else begin
         // Pulse outputs default low; the state that owns them raises them.
         r_mul_start <= 1'b0;
         r_res_valid <= 1'b0;
         r_ack       <= '0;
         case (r_state)
            S_IDLE: begin
               // The core is not reset, so it may still be busy here.
               if (w_found && !mul_busy) begin
                  r_mul_a     <= w_a;
                  r_mul_b     <= w_b;
                  r_id        <= w_win;
                  r_mul_start <= 1'b1;
                  r_arb_busy  <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_run_first <= 1'b1;
               r_state     <= S_RUN;
            end
            S_RUN: begin
               // First RUN cycle still sees the pre-start busy level.
               r_run_first <= 1'b0;
               if (!r_run_first && !mul_busy) begin
                  r_res_p     <= mul_p;
                  r_res_id    <= r_id;
                  r_res_valid <= 1'b1;
                  r_ack[r_id] <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
`ifndef MUL8_SHARE_ARB_FIXED_PRIO_EN
               r_ptr <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
`endif
               r_arb_busy <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ack       = r_ack;
   assign res_valid = r_res_valid;
   assign res_id    = r_res_id;
   assign res_p     = r_res_p;
   assign arb_busy  = r_arb_busy;
   assign mul_start = r_mul_start;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mul8_share_arb.sv
// ---------------------------------------------------------------------------
// tb_mul8_share_arb
//   Directed bench for mul8_share_arb (N=4). Contains a behavioural model of
//   the external multiplier core: busy for 8 cycles after the start edge,
//   product held on mul_p. Inputs are driven and outputs sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_mul8_share_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] a_bus = '0;
   logic [31:0] b_bus = '0;
   logic [3:0]  ack;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [7:0]  res_p;
   logic        arb_busy;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic        mul_busy;
   logic [7:0]  mul_p;

   int checks = 0;
   int errors = 0;

   // Core model (never reset, like the real core)
   int unsigned core_cnt   = 0;
   logic [7:0]  core_p     = '0;
   logic        force_busy = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mul_start) begin
         core_cnt <= 8;
         core_p   <= 8'(mul_a * mul_b);
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
      end
   end

   assign mul_busy = (core_cnt != 0) || force_busy;
   assign mul_p    = core_p;

   mul8_share_arb #(.N(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_bus     (a_bus),
      .b_bus     (b_bus),
      .ack       (ack),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_p     (res_p),
      .arb_busy  (arb_busy),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_busy  (mul_busy),
      .mul_p     (mul_p)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ack, res_valid, mul_start, arb_busy} !== 7'b0) begin
         $display("FAIL reset_ctrl got %b exp 0000000", {ack, res_valid, mul_start, arb_busy});
         errors++;
      end
      checks++;
      if ({res_id, res_p, mul_a, mul_b} !== 26'b0) begin
         $display("FAIL reset_data got %h exp 0", {res_id, res_p, mul_a, mul_b});
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      a_bus[15:8] = 8'd12;
      b_bus[15:8] = 8'd11;
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if ({mul_start, arb_busy, mul_a, mul_b} !== {1'b1, 1'b1, 8'd12, 8'd11}) begin
         $display("FAIL single_issue got st=%b bsy=%b a=%0d b=%0d exp st=1 bsy=1 a=12 b=11",
                  mul_start, arb_busy, mul_a, mul_b);
         errors++;
      end
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++;
         if ({res_valid, mul_start} !== 2'b00) begin
            $display("FAIL single_wait%0d got vld=%b st=%b exp 0 0", i, res_valid, mul_start);
            errors++;
         end
      end
      @(negedge clk);
      checks++;
      if ({res_valid, ack, res_id, res_p} !== {1'b1, 4'b0010, 2'd1, 8'd132}) begin
         $display("FAIL single_result got vld=%b ack=%b id=%0d p=%0d exp 1 0010 1 132",
                  res_valid, ack, res_id, res_p);
         errors++;
      end
      req = 4'b0000;
      @(negedge clk);
      checks++;
      if ({res_valid, ack, arb_busy} !== 6'b0) begin
         $display("FAIL single_after got vld=%b ack=%b bsy=%b exp 0 0000 0", res_valid, ack, arb_busy);
         errors++;
      end
   endtask

   task automatic test_wrap();
      logic [7:0] va [2];
      logic [7:0] vb [2];
      logic [7:0] vp [2];
      int cnt;
      va[0] = 8'd20;  vb[0] = 8'd13;  vp[0] = 8'd4;
      va[1] = 8'hFF;  vb[1] = 8'hFF;  vp[1] = 8'h01;
      for (int n = 0; n < 2; n++) begin
         a_bus[7:0] = va[n];
         b_bus[7:0] = vb[n];
         req = 4'b0001;
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (res_valid !== 1'b1 && cnt < 30);
         checks++;
         if (cnt !== 11) begin
            $display("FAIL wrap%0d_latency got %0d exp 11", n, cnt);
            errors++;
         end
         checks++;
         if ({ack, res_id, res_p} !== {4'b0001, 2'd0, vp[n]}) begin
            $display("FAIL wrap%0d_result got ack=%b id=%0d p=%h exp 0001 0 %h", n, ack, res_id, res_p, vp[n]);
            errors++;
         end
         req = 4'b0000;
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] pexp [4];
      int cnt;
      int exp_id;
      pexp[0] = 8'd21; pexp[1] = 8'd55; pexp[2] = 8'd120; pexp[3] = 8'd14;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_bus = {8'd9, 8'd7, 8'd5, 8'd3};
      b_bus = {8'd30, 8'd200, 8'd11, 8'd7};
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (res_valid !== 1'b1 && cnt < 30);
`ifdef MUL8_SHARE_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = n % 4;
`endif
         checks++;
         if (cnt !== ((n == 0) ? 11 : 12)) begin
            $display("FAIL rr%0d_spacing got %0d exp %0d", n, cnt, (n == 0) ? 11 : 12);
            errors++;
         end
         checks++;
         if ({ack, res_id, res_p} !== {4'(1 << exp_id), 2'(exp_id), pexp[exp_id]}) begin
            $display("FAIL rr%0d_result got ack=%b id=%0d p=%0d exp id=%0d p=%0d",
                     n, ack, res_id, res_p, exp_id, pexp[exp_id]);
            errors++;
         end
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
      checks++;
      if (arb_busy !== 1'b0) begin
         $display("FAIL rr_idle got bsy=%b exp 0", arb_busy);
         errors++;
      end
   endtask

   task automatic test_busy_start();
      int cnt;
      force_busy = 1'b1;
      rst = 1'b1;
      a_bus[7:0] = 8'd7;
      b_bus[7:0] = 8'd9;
      req = 4'b0001;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({mul_start, arb_busy} !== 2'b00) begin
            $display("FAIL busy_hold%0d got st=%b bsy=%b exp 0 0", i, mul_start, arb_busy);
            errors++;
         end
      end
      force_busy = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (mul_start !== 1'b1 && cnt < 30);
      checks++;
      if (cnt !== 1) begin
         $display("FAIL busy_start_delay got %0d exp 1", cnt);
         errors++;
      end
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (res_valid !== 1'b1 && cnt < 30);
      checks++;
      if ({cnt[4:0], ack, res_id, res_p} !== {5'd10, 4'b0001, 2'd0, 8'd63}) begin
         $display("FAIL busy_result got cyc=%0d ack=%b id=%0d p=%0d exp 10 0001 0 63", cnt, ack, res_id, res_p);
         errors++;
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cnt;
      a_bus[23:16] = 8'd30;
      b_bus[23:16] = 8'd9;
      req = 4'b0100;
      repeat (4) @(negedge clk);
      checks++;
      if ({arb_busy, mul_busy} !== 2'b11) begin
         $display("FAIL mid_running got bsy=%b mbsy=%b exp 1 1", arb_busy, mul_busy);
         errors++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ack, res_valid, arb_busy, mul_start} !== 7'b0) begin
         $display("FAIL mid_abort got ack=%b vld=%b bsy=%b st=%b exp all 0", ack, res_valid, arb_busy, mul_start);
         errors++;
      end
      rst = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (mul_start !== 1'b1 && cnt < 30);
      checks++;
      if (cnt !== 6) begin
         $display("FAIL mid_regrant got %0d exp 6", cnt);
         errors++;
      end
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (res_valid !== 1'b1 && cnt < 30);
      checks++;
      if ({cnt[4:0], ack, res_id, res_p} !== {5'd10, 4'b0100, 2'd2, 8'd14}) begin
         $display("FAIL mid_result got cyc=%0d ack=%b id=%0d p=%0d exp 10 0100 2 14", cnt, ack, res_id, res_p);
         errors++;
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_two_req();
      int cnt;
      int exp_id [3];
`ifdef MUL8_SHARE_ARB_FIXED_PRIO_EN
      exp_id[0] = 1; exp_id[1] = 1; exp_id[2] = 1;
`else
      exp_id[0] = 1; exp_id[1] = 3; exp_id[2] = 1;
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_bus = {8'd17, 8'd0, 8'd3, 8'd0};
      b_bus = {8'd15, 8'd0, 8'd4, 8'd0};
      req = 4'b1010;
      for (int n = 0; n < 3; n++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (res_valid !== 1'b1 && cnt < 30);
         checks++;
         if ({ack, res_id, res_p} !==
             {4'(1 << exp_id[n]), 2'(exp_id[n]), (exp_id[n] == 1) ? 8'd12 : 8'd255}) begin
            $display("FAIL two%0d_result got ack=%b id=%0d p=%0d exp id=%0d", n, ack, res_id, res_p, exp_id[n]);
            errors++;
         end
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_busy_start();
      test_reset_mid();
      test_two_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul8_share_arb.md
Name: mul8_share_arb

Overview:
- Shares one sequential 8x8 shift-add multiplier core among N requesters.
- Arbitrates round-robin, latches the winner's operands, and pulses the core's start.
- Waits out the 8-cycle busy window, then returns the 8-bit product with the requester ID.
- Sits between client blocks and a single multiplier instance, which is external to this block and connected via the mul_* ports.

Parameters:
- N, 4, number of requesters (2..8)
- ID_W, 2, width of the requester index; 2**ID_W >= N

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester level request; bit k = requester k
- a_bus  input  8*N  operand A; requester k on bits [8k+7:8k]
- b_bus  input  8*N  operand B, same packing
- ack  output  N  one-cycle completion pulse to the served requester
- res_valid  output  1  one-cycle pulse, result fields valid
- res_id  output  ID_W  index of the served requester
- res_p  output  8  product, (a*b) mod 256
- arb_busy  output  1  high whenever the FSM is not in IDLE
- mul_start  output  1  start pulse to the multiplier core
- mul_a  output  8  latched operand A to the core
- mul_b  output  8  latched operand B to the core
- mul_busy  input  1  core busy; high for 8 cycles starting the cycle after start
- mul_p  input  8  core product, stable while mul_busy is low

Behaviour:
- Reset values (rst high at a clock edge, takes priority over everything):
  - state=IDLE; ack, res_valid, mul_start, arb_busy = 0
  - res_id, res_p, mul_a, mul_b = 0
  - round-robin pointer = 0
- FSM states: IDLE -> ISSUE -> RUN -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Grants only when |req is high AND mul_busy is low. This covers the core being busy after power-up or after a reset mid-operation, since the core itself is not reset.
  - Winner = first set req bit searching upward from the pointer, wrapping from N-1 to 0.
  - On grant, latches the winner's a/b into mul_a/mul_b and its index into the ID register, and goes to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; go to RUN.
- RUN:
  - mul_start=0.
  - The first RUN cycle ignores mul_busy, so the start cycle's busy value is not mistaken for completion.
  - From the second RUN cycle onward, mul_busy low -> capture mul_p into res_p and go to DONE.
- DONE:
  - res_valid=1, res_id=winner, and ack[winner]=1, all for one cycle.
  - Pointer = winner+1, wrapping to 0 past N-1.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle T -> mul_start at T+1 -> core busy T+2..T+9 -> busy low sampled T+10 -> res_valid/ack at T+11.
- Throughput: the earliest next grant is in cycle T+12, i.e. one result per 12 cycles.
- Requester protocol:
  - Hold req high until ack; operands need only be stable in the grant cycle.
  - If req is dropped after the grant, the operation still completes and res_valid/ack still fire.
  - A req held high through ack counts as a new request from the next IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait and are never dropped.
- Fairness: with all N requesting continuously, each requester is served once per N operations.
- Requests that arrive while the FSM is not in IDLE are ignored until IDLE.
- Reset mid-operation: the FSM aborts with no ack or res_valid. After reset, the first grant waits until mul_busy is low.

Optional Feature:
- Macro: MUL8_SHARE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest requester index wins; the round-robin pointer is removed.
- Undefined (default): round-robin as described under Behaviour.

Test Plan:
- Single request: req=4'b0010, a1=8'd12, b1=8'd11 -> mul_start 1 cycle later; res_valid and ack=4'b0010 11 cycles after the request; res_p=8'd132, res_id=1.
- Wrap-around product: req0 with a=8'd20, b=8'd13 -> res_p=8'd4 (260 mod 256); a=8'hFF, b=8'hFF -> res_p=8'h01.
- Round-robin fairness: req=4'b1111 held continuously, distinct operands per requester -> served order 0,1,2,3,0; ack spacing 12 cycles; each res_p matches its requester's operands.
- Core busy at start: hold mul_busy high for 5 cycles after reset with req0 asserted -> no mul_start until mul_busy is low; then normal 11-cycle completion.
- Reset mid-operation: assert rst in RUN -> next cycle ack=0, res_valid=0, arb_busy=0; a pending request is regranted only once mul_busy is low.
- Fixed-priority build (MUL8_SHARE_ARB_FIXED_PRIO_EN defined): req=4'b1010 held continuously -> requester 1 is always served and requester 3 starves.
